program_loader: RTL and testbench
=================================

# program_loader

Boot-time instruction loader for the MIPS FPGA CPU. It accepts a byte stream with a valid/ready handshake, typically from a UART receiver, and assembles big-endian 32-bit instruction words. It writes each word into the instruction memory's write port at consecutive byte addresses and holds the CPU in reset until the whole program is loaded. It sits directly upstream of `cpu`: it drives the CPU's reset and fills the memory that `cpu` fetches from.

## Interface
- `DEPTH`, default 256: instruction memory capacity in words.
- `ADDR_W`, default 32: width of the byte address driven to instruction memory.
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader can accept a byte this cycle.
- `reload`  in  1  single-cycle request to start a new load; honoured only in RUN.
- `imem_we`  out  1  instruction memory write strobe.
- `imem_waddr`  out  ADDR_W  byte address of the word being written (word index × 4).
- `imem_wdata`  out  32  instruction word to write.
- `cpu_reset`  out  1  drives `cpu` reset; high while loading.
- `load_done`  out  1  high while in RUN.
- `load_error`  out  1  sticky: header word count exceeded `DEPTH`; cleared when the next load starts.

## Operation
- **Stream format**
  - 16-bit big-endian word count N, then 4·N bytes.
  - Each word is sent MSB first, so bytes 20 08 00 06 form 0x20080006.
- **Byte acceptance:** a byte is taken on any cycle with `rx_valid && rx_ready`.
- **States:** HDR_HI, HDR_LO, LOAD, WRITE, RUN.
  - HDR_HI: on accept, latch count[15:8]; go to HDR_LO.
  - HDR_LO: on accept, latch count[7:0].
    - If N==0, go to RUN.
    - Otherwise clear word index and byte counter; go to LOAD.
  - LOAD: accept bytes into the shift register. On the 4th byte, go to WRITE.
  - WRITE: one cycle.
    - If index < `DEPTH`, assert `imem_we` with `imem_waddr` = index·4.
    - If index ≥ `DEPTH`, suppress the write and set `load_error`.
    - Then increment index.
    - If index+1 == N, go to RUN; otherwise go to LOAD.
  - RUN: `cpu_reset`=0, `load_done`=1, `rx_ready`=0; bytes are ignored.
    - `reload`=1 clears `load_error`, asserts `cpu_reset`, and goes to HDR_HI.
- **Port behaviour per state:**
  - `rx_ready`=1 only in HDR_HI, HDR_LO and LOAD.
  - `rx_ready`=0 in WRITE and RUN, and during any cycle where `reset` is high.
  - `reload` is ignored outside RUN.
- **Overflow (N > `DEPTH`):** all 4·N bytes are still consumed so the stream stays framed. Only the first `DEPTH` words are written.
- **Memory contents:** never cleared by the loader. Words beyond N keep their previous values.

## Timing
- **Reset values** (applied in the cycle after `reset` is sampled high):
  - state HDR_HI
  - `cpu_reset`=1, `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0
  - `load_done`=0, `load_error`=0
  - byte counter and index = 0
- **Reset mid-load:** a partial word is discarded and the header must be resent.
- **Write latency:** `imem_we` is high exactly in the cycle after the 4th byte of a word is accepted. Address and data are stable in that cycle. Maximum throughput is 1 word per 5 cycles.
- **CPU release:** `cpu_reset` falls in the cycle after the last WRITE, or after HDR_LO when N=0. The last word is therefore in memory before the CPU's first fetch.
- **Reload:** `cpu_reset` rises in the cycle after `reload` is sampled in RUN.
- **Byte counter:** 2 bits; wraps 3→0 on entering WRITE.
- **Index:** 16 bits. N=65535 must not wrap before the terminal comparison.

## Structure
- Shared package `mips_pkg`: the loader state enum and the header width constant (16).
- Sub-module `word_assembler`:
  - 4-byte shift register plus 2-bit counter.
  - Inputs: shift enable and byte. Outputs: 32-bit word and `word_complete`.
- Top level `program_loader`: FSM, index counter, error flag, output registers. Instantiated next to `cpu`, with `cpu_reset` wired to `cpu`'s reset.

## Test plan
- **Basic load:** stream 00 02 20 08 00 06 20 09 00 0B.
  - Two write pulses: (addr 0, 0x20080006) and (addr 4, 0x2009000B).
  - `cpu_reset` falls one cycle after the second pulse; `load_done`=1.
  - Instruction memory data[0..1] match.
- **Empty program:** stream 00 00.
  - No `imem_we` pulse; `cpu_reset` falls the cycle after the 2nd byte is accepted.
- **Gapped valid:** `rx_valid` toggles every other cycle during a 3-word load.
  - Words are assembled correctly and exactly 3 writes occur.
- **Overflow:** `DEPTH`=4, N=6, followed by 24 bytes.
  - Writes go to addresses 0–12 only; `load_error`=1.
  - All bytes are consumed, then RUN is entered.
- **Reset mid-load:** assert `reset` after 2 bytes of word 1, then send a new 1-word stream.
  - Word is written to addr 0 with the new value; no stale bytes.
- **Reload:** in RUN, pulse `reload` and load 00 01 AC 08 00 00.
  - `cpu_reset` rises next cycle and `load_error` clears.
  - 0xAC080000 is written to addr 0, then `cpu_reset` falls again.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS FPGA boot path: loader states and stream widths.
package mips_pkg;

  localparam int unsigned HDR_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    LD_HDR_HI = 3'd0,
    LD_HDR_LO = 3'd1,
    LD_LOAD   = 3'd2,
    LD_WRITE  = 3'd3,
    LD_RUN    = 3'd4
  } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs a big-endian byte stream into 32-bit words, MSB first.
module word_assembler
  import mips_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] din,
  output logic [WORD_W-1:0] word,
  output logic              word_complete
);

  logic [1:0] cnt_q;

  // This shift completes a word when three bytes are already held.
  assign word_complete = shift_en && (cnt_q == 2'd3);

  // Shift register and byte counter; counter wraps 3->0 on the completing byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      word  <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (shift_en) begin
      word  <= {word[WORD_W-BYTE_W-1:0], din};
      cnt_q <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot-time loader: reads a counted byte stream, writes instruction memory,
// and holds the CPU in reset until the whole program is in place.
module program_loader
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error
);

  loader_state_t     state_q, state_d;
  logic [HDR_W-1:0]  count_q, count_d;
  logic [HDR_W-1:0]  index_q, index_d;
  logic [HDR_W:0]    index_plus1;
  logic              in_range;
  logic              accept;
  logic              asm_clear, asm_shift, word_complete;
  logic              imem_we_d, cpu_reset_d, load_done_d, load_error_d;
  logic [ADDR_W-1:0] imem_waddr_d;

  // Byte intake is open only while parsing the header or collecting word bytes.
  assign rx_ready = !reset && ((state_q == LD_HDR_HI) || (state_q == LD_HDR_LO) ||
                               (state_q == LD_LOAD));
  assign accept   = rx_valid && rx_ready;

  // Index is compared one bit wider so a 65535-word program cannot wrap early.
  assign index_plus1 = {1'b0, index_q} + (HDR_W + 1)'(1);
  assign in_range    = 32'(index_q) < 32'(DEPTH);

  word_assembler u_word_assembler (
    .clock         (clock),
    .reset         (reset),
    .clear         (asm_clear),
    .shift_en      (asm_shift),
    .din           (rx_data),
    .word          (imem_wdata),
    .word_complete (word_complete)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    index_d      = index_q;
    imem_we_d    = 1'b0;
    imem_waddr_d = imem_waddr;
    load_error_d = load_error;
    asm_clear    = 1'b0;
    asm_shift    = 1'b0;

    unique case (state_q)
      LD_HDR_HI: begin
        if (accept) begin
          count_d[15:8] = rx_data;
          state_d       = LD_HDR_LO;
        end
      end
      LD_HDR_LO: begin
        if (accept) begin
          count_d[7:0] = rx_data;
          if ({count_q[15:8], rx_data} == '0) begin
            state_d = LD_RUN;
          end else begin
            index_d   = '0;
            asm_clear = 1'b1;
            state_d   = LD_LOAD;
          end
        end
      end
      LD_LOAD: begin
        asm_shift = accept;
        if (accept && word_complete) begin
          imem_we_d    = in_range;
          imem_waddr_d = ADDR_W'({index_q, 2'b00});
          state_d      = LD_WRITE;
        end
      end
      LD_WRITE: begin
        if (!in_range) load_error_d = 1'b1;
        index_d = index_plus1[HDR_W-1:0];
        state_d = (index_plus1 == {1'b0, count_q}) ? LD_RUN : LD_LOAD;
      end
      LD_RUN: begin
        if (reload) begin
          load_error_d = 1'b0;
          state_d      = LD_HDR_HI;
        end
      end
      default: state_d = LD_HDR_HI;
    endcase

    cpu_reset_d = (state_d != LD_RUN);
    load_done_d = (state_d == LD_RUN);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= LD_HDR_HI;
      count_q    <= '0;
      index_q    <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      index_q    <= index_d;
      imem_we    <= imem_we_d;
      imem_waddr <= imem_waddr_d;
      cpu_reset  <= cpu_reset_d;
      load_done  <= load_done_d;
      load_error <= load_error_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader with a small memory (DEPTH=4).
module tb_program_loader;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              reload = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset, load_done, load_error;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] words[$];
  logic [31:0] imem[DEPTH];     // memory as seen through the write port
  logic [31:0] ref_mem[DEPTH];  // memory as the stream rules say it should be
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clock = ~clock;

  program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the next expected write.
  always @(negedge clock) begin
    if (!reset && imem_we) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr %h data %h at %0t", imem_waddr, imem_wdata, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", imem_waddr, e.addr);
        chk("write_data", imem_wdata, e.data);
      end
      if ((imem_waddr >> 2) < DEPTH) imem[imem_waddr >> 2] = imem_wdata;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit done;
    if (gap) begin
      rx_valid = 1'b0;
      @(posedge clock);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    done     = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clock);
      if (rx_ready) done = 1'b1;
      @(posedge clock);
      #1;
    end
    rx_valid = 1'b0;
    if (!done) chk("byte_accept_timeout", 32'(rx_ready), 32'd1);
  endtask

  task automatic do_reset(input int cycles);
    reset    = 1'b1;
    rx_valid = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clock);
      chk("ready_in_reset", 32'(rx_ready), 32'd0);
      @(posedge clock);
      #1;
    end
    reset    = 1'b0;
    rx_valid = 1'b0;
    @(negedge clock);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_error", 32'(load_error), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_waddr", imem_waddr, 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clock);
    #1;
    reload = 1'b0;
    @(negedge clock);
    chk("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("reload_load_done", 32'(load_done), 32'd0);
    chk("reload_error_clr", 32'(load_error), 32'd0);
    @(posedge clock);
    #1;
  endtask

  // Sends the program in words[], predicting writes, release timing and error flag.
  task automatic load_program(input bit gapped, input bit hold_reload);
    int          n;
    logic [15:0] nn;
    logic [7:0]  bytes[$];
    n  = words.size();
    nn = 16'(n);
    for (int i = 0; i < n; i++) begin
      wr_t e;
      if (i < DEPTH) begin
        e.addr = 32'(i * 4);
        e.data = words[i];
        exp_q.push_back(e);
        ref_mem[i] = words[i];
      end
    end
    bytes.push_back(nn[15:8]);
    bytes.push_back(nn[7:0]);
    foreach (words[i]) begin
      logic [31:0] w;
      w = words[i];
      bytes.push_back(w[31:24]);
      bytes.push_back(w[23:16]);
      bytes.push_back(w[15:8]);
      bytes.push_back(w[7:0]);
    end
    reload = hold_reload;
    foreach (bytes[i]) send_byte(bytes[i], gapped && (i % 2 == 1));
    reload = 1'b0;
    @(negedge clock);
    if (n > 0) begin
      chk("write_cycle_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("write_cycle_ready", 32'(rx_ready), 32'd0);
      chk("last_we", 32'(imem_we), 32'((n - 1) < DEPTH));
      @(negedge clock);
    end
    chk("release_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("release_load_done", 32'(load_done), 32'd1);
    chk("run_ready", 32'(rx_ready), 32'd0);
    chk("load_error", 32'(load_error), 32'(n > DEPTH));
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < DEPTH; i++) chk($sformatf("mem[%0d]", i), imem[i], ref_mem[i]);
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      imem[i]    = 32'hDEAD_0000 + 32'(i);
      ref_mem[i] = 32'hDEAD_0000 + 32'(i);
    end
    @(posedge clock);
    #1;
    do_reset(2);

    // Basic two-word load.
    words = '{32'h2008_0006, 32'h2009_000B};
    load_program(1'b0, 1'b0);

    // Bytes offered in RUN are ignored.
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("run_ignores_bytes", 32'(rx_ready), 32'd0);
      @(posedge clock);
      #1;
    end
    rx_valid = 1'b0;

    // Empty program.
    do_reload();
    words = {};
    load_program(1'b0, 1'b0);

    // Gapped valid, three words, reload held high to show it is ignored while loading.
    do_reload();
    words = '{$urandom(), $urandom(), $urandom()};
    load_program(1'b1, 1'b1);

    // Overflow: six words into a four-word memory.
    do_reload();
    words = {};
    for (int i = 0; i < 6; i++) words.push_back($urandom());
    load_program(1'b0, 1'b0);

    // Reload clears the error and loads a single store word.
    do_reload();
    words = '{32'hAC08_0000};
    load_program(1'b0, 1'b0);

    // Reset mid-load: partial word must be discarded.
    do_reset(1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    do_reset(1);
    words = '{$urandom()};
    load_program(1'b0, 1'b0);

    // Randomized programs, some overflowing.
    for (int r = 0; r < 8; r++) begin
      int n;
      do_reload();
      n = $urandom_range(0, 7);
      words = {};
      for (int i = 0; i < n; i++) words.push_back($urandom());
      load_program(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
